// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the PS/2 set-2 scan code controller.
//   state_t      - controller FSM states
//   PFX_*        - prefix bytes (extended, break, pause sequence)
//   SC_*         - scan codes with special handling (modifiers, Pause)
//   is_discard() - true for controller/status bytes that carry no key event
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_DECODE,
        ST_EMIT
    } state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_PAUSE  = 8'h77;

    // Pause is E1 followed by seven bytes that are swallowed whole.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_discard = 1'b1;
            default:                                  is_discard = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scancode_ascii_rom.sv
// scancode_ascii_rom: combinational set-2 scan code to US ASCII translation.
//   code  - set-2 scan code without prefixes
//   shift - shift held
//   caps  - caps lock active (affects letters only)
//   ctrl  - ctrl held (letters map to 0x01-0x1A when CTRL_MAP != 0)
//   ascii - translated character, 0x00 when the code has no mapping
module scancode_ascii_rom #(
    parameter int CTRL_MAP = 1
) (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic [7:0] ascii
);

    // Alphabet position 1..26, 0 for non-letters.
    function automatic logic [4:0] letter_idx(input logic [7:0] c);
        case (c)
            8'h1C: letter_idx = 5'd1;   8'h32: letter_idx = 5'd2;
            8'h21: letter_idx = 5'd3;   8'h23: letter_idx = 5'd4;
            8'h24: letter_idx = 5'd5;   8'h2B: letter_idx = 5'd6;
            8'h34: letter_idx = 5'd7;   8'h33: letter_idx = 5'd8;
            8'h43: letter_idx = 5'd9;   8'h3B: letter_idx = 5'd10;
            8'h42: letter_idx = 5'd11;  8'h4B: letter_idx = 5'd12;
            8'h3A: letter_idx = 5'd13;  8'h31: letter_idx = 5'd14;
            8'h44: letter_idx = 5'd15;  8'h4D: letter_idx = 5'd16;
            8'h15: letter_idx = 5'd17;  8'h2D: letter_idx = 5'd18;
            8'h1B: letter_idx = 5'd19;  8'h2C: letter_idx = 5'd20;
            8'h3C: letter_idx = 5'd21;  8'h2A: letter_idx = 5'd22;
            8'h1D: letter_idx = 5'd23;  8'h22: letter_idx = 5'd24;
            8'h35: letter_idx = 5'd25;  8'h1A: letter_idx = 5'd26;
            default: letter_idx = 5'd0;
        endcase
    endfunction

    // Non-letter keys: {shifted, unshifted}; 0 means unmapped.
    function automatic logic [15:0] symbol(input logic [7:0] c);
        case (c)
            8'h16: symbol = {8'h21, 8'h31};  8'h1E: symbol = {8'h40, 8'h32};
            8'h26: symbol = {8'h23, 8'h33};  8'h25: symbol = {8'h24, 8'h34};
            8'h2E: symbol = {8'h25, 8'h35};  8'h36: symbol = {8'h5E, 8'h36};
            8'h3D: symbol = {8'h26, 8'h37};  8'h3E: symbol = {8'h2A, 8'h38};
            8'h46: symbol = {8'h28, 8'h39};  8'h45: symbol = {8'h29, 8'h30};
            8'h0E: symbol = {8'h7E, 8'h60};  8'h4E: symbol = {8'h5F, 8'h2D};
            8'h55: symbol = {8'h2B, 8'h3D};  8'h54: symbol = {8'h7B, 8'h5B};
            8'h5B: symbol = {8'h7D, 8'h5D};  8'h5D: symbol = {8'h7C, 8'h5C};
            8'h4C: symbol = {8'h3A, 8'h3B};  8'h52: symbol = {8'h22, 8'h27};
            8'h41: symbol = {8'h3C, 8'h2C};  8'h49: symbol = {8'h3E, 8'h2E};
            8'h4A: symbol = {8'h3F, 8'h2F};
            8'h29: symbol = {8'h20, 8'h20};  8'h5A: symbol = {8'h0D, 8'h0D};
            8'h66: symbol = {8'h08, 8'h08};  8'h0D: symbol = {8'h09, 8'h09};
            8'h76: symbol = {8'h1B, 8'h1B};
            default: symbol = 16'h0000;
        endcase
    endfunction

    logic [4:0]  letter;
    logic [15:0] sym;

    always_comb begin
        letter = letter_idx(code);
        sym    = symbol(code);
        ascii  = 8'h00;
        if (letter != 5'd0) begin
            if ((CTRL_MAP != 0) && ctrl)
                ascii = {3'b000, letter};
            else if (shift ^ caps)
                ascii = 8'h40 | {3'b000, letter};
            else
                ascii = 8'h60 | {3'b000, letter};
        end else begin
            ascii = shift ? sym[15:8] : sym[7:0];
        end
    end

endmodule

// File: rtl/kbd_scancode_ctrl.sv
// kbd_scancode_ctrl: pops bytes from a PS/2 receiver FIFO, assembles set-2
// scan code sequences into key events, tracks modifiers and translates to ASCII.
//   clk, rst           - clock, asynchronous active-high reset
//   rx_data/rx_ready   - receiver FIFO head byte and non-empty flag
//   rx_overflow        - receiver overflow flag (latched into err_overflow)
//   rx_nextdata_n      - active-low one-cycle pop strobe
//   key_valid/key_ack  - event handshake; outputs hold until acknowledged
//   key_code/ext/release/ascii - event contents
//   mod_shift/mod_ctrl/caps_lock - modifier state
module kbd_scancode_ctrl
    import kbd_pkg::*;
#(
    parameter int TYPEMATIC_FILTER = 1,
    parameter int CTRL_MAP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_overflow,
    output logic       rx_nextdata_n,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic [7:0] key_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       caps_lock,
    output logic       err_overflow
);

    state_t     state;
    logic [7:0] byte_q;
    logic       ext_q;
    logic       brk_q;
    logic [2:0] skip_q;
    logic       caps_held;
    logic       match_vld;
    logic       match_ext;
    logic [7:0] match_code;

    // Modifier state as it will be after the byte in byte_q is applied, so
    // the translation of this very byte already sees it.
    logic       shift_nxt;
    logic       ctrl_nxt;
    logic       caps_nxt;
    logic       caps_held_nxt;
    logic       is_dup;
    logic       match_hit;
    logic [7:0] rom_ascii;

    always_comb begin
        shift_nxt     = mod_shift;
        ctrl_nxt      = mod_ctrl;
        caps_nxt      = caps_lock;
        caps_held_nxt = caps_held;
        if (!ext_q && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT))
            shift_nxt = !brk_q;
        if (byte_q == SC_CTRL)
            ctrl_nxt = !brk_q;
        if (!ext_q && byte_q == SC_CAPS) begin
            caps_held_nxt = !brk_q;
            // Only the first make of a held key toggles; typematic repeats don't.
            if (!brk_q && !caps_held)
                caps_nxt = !caps_lock;
        end
        match_hit = match_vld && (match_ext == ext_q) && (match_code == byte_q);
        is_dup    = (TYPEMATIC_FILTER != 0) && !brk_q && match_hit;
    end

    scancode_ascii_rom #(
        .CTRL_MAP (CTRL_MAP)
    ) u_rom (
        .code  (byte_q),
        .shift (shift_nxt),
        .caps  (caps_nxt),
        .ctrl  (ctrl_nxt),
        .ascii (rom_ascii)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_q        <= 8'h00;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            skip_q        <= 3'd0;
            caps_held     <= 1'b0;
            match_vld     <= 1'b0;
            match_ext     <= 1'b0;
            match_code    <= 8'h00;
            rx_nextdata_n <= 1'b1;
            key_valid     <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_release   <= 1'b0;
            key_ascii     <= 8'h00;
            mod_shift     <= 1'b0;
            mod_ctrl      <= 1'b0;
            caps_lock     <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (rx_overflow)
                err_overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_ready) begin
                        byte_q        <= rx_data;
                        rx_nextdata_n <= 1'b0;
                        state         <= ST_POP;
                    end
                end

                ST_POP: begin
                    rx_nextdata_n <= 1'b1;
                    state         <= ST_DECODE;
                end

                ST_DECODE: begin
                    state <= ST_IDLE;
                    if (skip_q != 3'd0) begin
                        // Inside the Pause sequence: swallow, emit once at the end.
                        skip_q <= skip_q - 3'd1;
                        if (skip_q == 3'd1) begin
                            key_code    <= SC_PAUSE;
                            key_ext     <= 1'b1;
                            key_release <= 1'b0;
                            key_ascii   <= 8'h00;
                            key_valid   <= 1'b1;
                            state       <= ST_EMIT;
                        end
                    end else if (byte_q == PFX_E0) begin
                        ext_q <= 1'b1;
                    end else if (byte_q == PFX_F0) begin
                        brk_q <= 1'b1;
                    end else if (byte_q == PFX_E1) begin
                        skip_q <= PAUSE_SKIP;
                    end else if (is_discard(byte_q)) begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end else begin
                        mod_shift <= shift_nxt;
                        mod_ctrl  <= ctrl_nxt;
                        caps_lock <= caps_nxt;
                        caps_held <= caps_held_nxt;
                        ext_q     <= 1'b0;
                        brk_q     <= 1'b0;
                        if (brk_q) begin
                            if (match_hit)
                                match_vld <= 1'b0;
                        end else if (!is_dup) begin
                            match_vld  <= 1'b1;
                            match_ext  <= ext_q;
                            match_code <= byte_q;
                        end
                        if (!is_dup) begin
                            key_code    <= byte_q;
                            key_ext     <= ext_q;
                            key_release <= brk_q;
                            key_ascii   <= (ext_q || brk_q) ? 8'h00 : rom_ascii;
                            key_valid   <= 1'b1;
                            state       <= ST_EMIT;
                        end
                    end
                end

                ST_EMIT: begin
                    if (key_ack) begin
                        key_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/kbd_scancode_ctrl.md
KBD_SCANCODE_CTRL -- requirements
Module: kbd_scancode_ctrl

Interface
REQ-001 SHALL have parameter TYPEMATIC_FILTER, default 1, meaning: 1 = suppress repeated make codes of a held key.
REQ-002 SHALL have parameter CTRL_MAP, default 1, meaning: 1 = Ctrl+letter maps to ASCII 0x01-0x1A.
REQ-003 SHALL have clk  input  1  system clock.
REQ-004 SHALL have rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have rx_data  input  8  receiver FIFO head byte, valid while rx_ready=1.
REQ-006 SHALL have rx_ready  input  1  receiver FIFO non-empty.
REQ-007 SHALL have rx_overflow  input  1  receiver FIFO overflow flag.
REQ-008 SHALL have rx_nextdata_n  output  1  active-low pop strobe to the receiver.
REQ-009 SHALL have key_valid  output  1  key event pending.
REQ-010 SHALL have key_ack  input  1  consumer accepts the event.
REQ-011 SHALL have key_code  output  8  set-2 scan code, no prefix.
REQ-012 SHALL have key_ext  output  1  event carried an E0 prefix or is Pause.
REQ-013 SHALL have key_release  output  1  event carried an F0 prefix.
REQ-014 SHALL have key_ascii  output  8  translated ASCII; 0x00 if unmapped.
REQ-015 SHALL have mod_shift, mod_ctrl, caps_lock  output  1 each  modifier state.
REQ-016 SHALL have err_overflow  output  1  sticky copy of rx_overflow.

Function
REQ-017 SHALL implement Moore FSM IDLE, POP, DECODE, EMIT.
REQ-018 IDLE: if rx_ready=1, latch rx_data into byte register -> POP; otherwise stay.
REQ-019 POP: rx_nextdata_n=0 for exactly one cycle -> DECODE; rx_nextdata_n=1 in all other states.
REQ-020 DECODE: byte E0 -> set ext flag, IDLE; F0 -> set brk flag, IDLE; repeated prefixes SHALL be idempotent.
REQ-021 DECODE: E1 -> load skip counter with 7, IDLE; while skip counter >0 each popped byte SHALL decrement it without decoding; on reaching 0 one event SHALL be emitted: code 0x77, key_ext=1, key_release=0.
REQ-022 DECODE: bytes 00, AA, EE, FA, FE, FF SHALL be discarded and clear ext/brk -> IDLE.
REQ-023 DECODE of any other byte SHALL update modifiers, load key_* outputs, clear ext/brk, go to EMIT.
REQ-024 Modifiers: 12/59 (shift), 14 (ctrl, with or without E0) SHALL set on make and clear on break; 58 make SHALL toggle caps_lock only if caps was not already held.
REQ-025 TYPEMATIC_FILTER=1: a make whose {ext,code} equals the last make with no intervening break of it SHALL be dropped (no EMIT); any break clears the match register if equal.
REQ-026 EMIT: key_valid=1, outputs stable until key_ack=1 sampled; then IDLE the next cycle; no further pop SHALL occur while in EMIT.
REQ-027 key_ack while key_valid=0 SHALL be ignored.
REQ-028 ASCII: letters uppercase iff mod_shift XOR caps_lock; digits/punctuation use US shift symbols; 29->20, 5A->0D, 66->08, 0D->09, 76->1B; ext codes and releases yield 0x00.
REQ-029 CTRL_MAP=1 and mod_ctrl=1: letter yields 0x01-0x1A regardless of shift/caps.
REQ-030 ASCII SHALL use modifier state after the current byte updates it.
REQ-031 err_overflow SHALL set when rx_overflow=1 and hold until reset.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, rx_nextdata_n=1, key_valid=0, key_code=00, key_ascii=00, key_ext=0, key_release=0, all modifiers 0, ext/brk/skip/match cleared, err_overflow=0.
REQ-033 Reset during POP or EMIT SHALL abandon the byte/event without a second pop after release.

Structure
REQ-034 FSM state type, prefix constants (E0, F0, E1) and discard-code list SHALL live in shared package kbd_pkg.
REQ-035 ASCII translation SHALL be combinational sub-module scancode_ascii_rom (inputs code, shift, caps, ctrl; output ascii).

Verification
REQ-036 Bytes 1C, F0 1C, ack each -> two events code 1C ascii 61, release 0 then 1 ascii 00.
REQ-037 12, 1C, 1C, F0 1C, F0 12 -> events: 12 make, 1C ascii 41 once (second 1C dropped), 1C release, 12 release; mod_shift 1 then 0.
REQ-038 E0 F0 75 -> one event code 75, key_ext=1, key_release=1; FA and AA in stream -> no event.
REQ-039 E1 14 77 E1 F0 14 F0 77 -> exactly one event code 77 ext=1; exactly 8 pops.
REQ-040 58, F0 58, 58 with ack withheld 20 cycles -> key_valid held, rx_nextdata_n stays 1, caps_lock ends 0 after toggling twice; rst asserted in EMIT -> all outputs reset values same cycle.
